// File: rtl/barrel_shifter_if.sv
// Operand/result bundle between the datapath and the barrel shifter.
// master drives the shift request, slave returns the registered result.
interface barrel_shifter_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       Sh;
   logic [4:0]       Shamt5;
   logic [WIDTH-1:0] ShIn;
   logic             CarryIn;
   logic [WIDTH-1:0] ShOut;
   logic             ShCarry;

   modport master (output Sh, Shamt5, ShIn, CarryIn, input ShOut, ShCarry);
   modport slave  (input Sh, Shamt5, ShIn, CarryIn, output ShOut, ShCarry);
endinterface

// File: rtl/barrel_shifter.sv
// ARM-style LSL/LSR/ASR/ROR barrel shifter with carry-out, one cycle latency.
// Logarithmic network of five conditional stages (1, 2, 4, 8, 16) feeding an output register.
module barrel_shifter_stage #(
   parameter int W = 32,
   parameter int K = 1
) (
   input  logic [1:0]   sh,
   input  logic         en,
   input  logic [W-1:0] d,
   input  logic         c,
   output logic [W-1:0] q,
   output logic         co
);
   // Each stage forwards the carry of the last bit it shifted out, so the
   // final carry comes from whichever enabled stage ran last.
   always_comb begin
      q  = d;
      co = c;
      if (en) begin
         case (sh)
            2'b00: begin
               q  = {d[W-K-1:0], {K{1'b0}}};
               co = d[W-K];
            end
            2'b01: begin
               q  = {{K{1'b0}}, d[W-1:K]};
               co = d[K-1];
            end
            2'b10: begin
               q  = {{K{d[W-1]}}, d[W-1:K]};
               co = d[K-1];
            end
            default: begin
               q  = {d[K-1:0], d[W-1:K]};
               co = d[K-1];
            end
         endcase
      end
   end
endmodule

module barrel_shifter #(
   parameter int WIDTH = 32
) (
   input logic           CLK,
   input logic           Reset,
   barrel_shifter_if.slave bus
);
   localparam int STAGES = 5;

   logic [STAGES:0][WIDTH-1:0] stage_d;
   logic [STAGES:0]            stage_c;

   assign stage_d[0] = bus.ShIn;
   assign stage_c[0] = bus.CarryIn;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      barrel_shifter_stage #(
         .W (WIDTH),
         .K (1 << i)
      ) u_stage (
         .sh (bus.Sh),
         .en (bus.Shamt5[i]),
         .d  (stage_d[i]),
         .c  (stage_c[i]),
         .q  (stage_d[i+1]),
         .co (stage_c[i+1])
      );
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         bus.ShOut   <= '0;
         bus.ShCarry <= 1'b0;
      end else begin
         bus.ShOut   <= stage_d[STAGES];
         bus.ShCarry <= stage_c[STAGES];
      end
   end
endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed vectors plus a randomized
// sweep against a wide-arithmetic reference model.
module tb_barrel_shifter;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   barrel_shifter_if #(.WIDTH(32)) bif ();

   barrel_shifter #(.WIDTH(32)) dut (
      .CLK   (clk),
      .Reset (rst),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: shift inside a 64-bit window so the carry is just the bit
   // sitting next to the result field.
   function automatic logic [32:0] model(input logic [1:0] sh, input logic [4:0] n,
                                         input logic [31:0] x, input logic cin);
      logic [63:0] t;
      logic [31:0] o;
      if (n == 0) return {cin, x};
      case (sh)
         2'd0: begin t = {32'h0, x} << n; return {t[32], t[31:0]}; end
         2'd1: begin t = {x, 32'h0} >> n; return {t[31], t[63:32]}; end
         2'd2: begin t = $signed({x, 32'h0}) >>> n; return {t[31], t[63:32]}; end
         default: begin t = {x, x} >> n; o = t[31:0]; return {o[31], o}; end
      endcase
   endfunction

   task automatic drive(input logic [1:0] sh, input logic [4:0] n,
                        input logic [31:0] x, input logic cin);
      @(negedge clk);
      bif.Sh = sh; bif.Shamt5 = n; bif.ShIn = x; bif.CarryIn = cin;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bif.Sh = 2'd0; bif.Shamt5 = 5'd0; bif.ShIn = 32'hFFFF_FFFF; bif.CarryIn = 1'b1;
      #1;
      total++;
      if (bif.ShOut !== 32'h0 || bif.ShCarry !== 1'b0) begin
         bad++;
         $display("FAIL reset_initial out=%h c=%b want 0/0", bif.ShOut, bif.ShCarry);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bif.ShOut !== 32'h0 || bif.ShCarry !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold out=%h c=%b want 0/0", bif.ShOut, bif.ShCarry);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (bif.ShOut !== 32'hFFFF_FFFF || bif.ShCarry !== 1'b1) begin
         bad++;
         $display("FAIL reset_release out=%h c=%b want ffffffff/1", bif.ShOut, bif.ShCarry);
      end
      // mid-cycle assertion must clear outputs with no clock edge
      drive(2'd3, 5'd4, 32'h2914AB4E, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (bif.ShOut !== 32'h0 || bif.ShCarry !== 1'b0) begin
         bad++;
         $display("FAIL reset_async out=%h c=%b want 0/0", bif.ShOut, bif.ShCarry);
      end
      @(posedge clk);
      #1;
      total++;
      if (bif.ShOut !== 32'h0 || bif.ShCarry !== 1'b0) begin
         bad++;
         $display("FAIL reset_async_hold out=%h c=%b want 0/0", bif.ShOut, bif.ShCarry);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(2'd0, 5'd1, 32'h2914AB4E, 1'b0);
      total++;
      if (bif.ShOut !== 32'h5229569C || bif.ShCarry !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_load out=%h c=%b want 5229569c/0", bif.ShOut, bif.ShCarry);
      end
   endtask

   task automatic test_zero_shift;
      for (int s = 0; s < 4; s++) begin
         drive(2'(s), 5'd0, 32'h2914AB4E, 1'b1);
         total++;
         if (bif.ShOut !== 32'h2914AB4E || bif.ShCarry !== 1'b1) begin
            bad++;
            $display("FAIL zero_shift sh=%0d out=%h c=%b want 2914ab4e/1", s, bif.ShOut, bif.ShCarry);
         end
      end
   endtask

   task automatic test_directed;
      logic [1:0]  sh_t [10]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd1};
      logic [4:0]  n_t  [10]  = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd31, 5'd31, 5'd31, 5'd4, 5'd4, 5'd4};
      logic [31:0] in_t [10]  = '{32'h2914AB4E, 32'h2914AB4E, 32'h2914AB4E, 32'h2914AB4E,
                                  32'h2914AB4E, 32'h2914AB4E, 32'h2914AB4E, 32'h2914AB4E,
                                  32'h80000000, 32'h80000000};
      logic [31:0] out_t[10]  = '{32'h5229569C, 32'h148A55A7, 32'h148A55A7, 32'h148A55A7,
                                  32'h00000000, 32'h00000000, 32'h5229569C, 32'hE2914AB4,
                                  32'hF8000000, 32'h08000000};
      logic        c_t  [10]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(sh_t[i], n_t[i], in_t[i], ~c_t[i]);
         total++;
         if (bif.ShOut !== out_t[i] || bif.ShCarry !== c_t[i]) begin
            bad++;
            $display("FAIL directed_%0d sh=%0d n=%0d out=%h c=%b want %h/%b",
                     i, sh_t[i], n_t[i], bif.ShOut, bif.ShCarry, out_t[i], c_t[i]);
         end
      end
   endtask

   // Back-to-back random vectors; also confirms outputs do not move until the edge.
   task automatic test_random;
      logic [32:0] prev;
      logic [32:0] exp;
      logic [1:0]  sh;
      logic [4:0]  n;
      logic [31:0] x;
      logic        cin;
      prev = {bif.ShCarry, bif.ShOut};
      for (int i = 0; i < 300; i++) begin
         sh  = 2'($urandom_range(0, 3));
         n   = 5'($urandom_range(0, 31));
         x   = $urandom;
         if (i % 7 == 0) x[31] = 1'b1;
         cin = 1'($urandom);
         exp = model(sh, n, x, cin);
         @(negedge clk);
         bif.Sh = sh; bif.Shamt5 = n; bif.ShIn = x; bif.CarryIn = cin;
         #1;
         total++;
         if ({bif.ShCarry, bif.ShOut} !== prev) begin
            bad++;
            $display("FAIL random_latency_%0d early out=%h c=%b want %h/%b",
                     i, bif.ShOut, bif.ShCarry, prev[31:0], prev[32]);
         end
         @(posedge clk);
         #1;
         total++;
         if ({bif.ShCarry, bif.ShOut} !== exp) begin
            bad++;
            $display("FAIL random_%0d sh=%0d n=%0d in=%h cin=%b out=%h c=%b want %h/%b",
                     i, sh, n, x, cin, bif.ShOut, bif.ShCarry, exp[31:0], exp[32]);
         end
         prev = exp;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_zero_shift();
      test_directed();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
